// File: rtl/catcore_pkg.sv
// Shared CatCore definitions: command characters, frame sizes, FSM encodings and the request struct.
package catcore_pkg;

    localparam logic [7:0] CMD_SEND_TX = 8'h40;  // "@"
    localparam logic [7:0] CMD_SHOOT   = 8'h41;  // "A"
    localparam logic [7:0] CMD_AES_KEY = 8'h42;  // "B"
    localparam logic [7:0] CMD_AES_PT  = 8'h43;  // "C"
    localparam logic [7:0] CMD_PRIV    = 8'h44;  // "D"
    localparam logic [7:0] CMD_DES     = 8'h47;  // "G"
    localparam logic [7:0] CMD_DEV_MEM = 8'h61;  // "a"

    localparam int unsigned CATCORE_FRAME_BYTES = 18;
    localparam int unsigned SHOOT_FRAME_BYTES   = 3;
    localparam int unsigned PAYLOAD_W           = 8 * (CATCORE_FRAME_BYTES - 2);
    localparam int unsigned LEN_W               = 5;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_BYTE,
        FRM_GAP,
        FRM_DONE
    } frm_state_e;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

    typedef struct packed {
        logic [7:0]           cmd;
        logic [PAYLOAD_W-1:0] payload;
        logic [LEN_W-1:0]     len;
    } frame_req_t;

    // Frames always carry both cmd copies, and never exceed the buffer.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input int unsigned      max_len);
        if (len < LEN_W'(2)) begin
            return LEN_W'(2);
        end
        if (32'(len) > max_len) begin
            return LEN_W'(max_len);
        end
        return len;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser with its own bit timer; a start in the last stop cycle chains the next byte.
module uart_tx_byte
    import catcore_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10752
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done_c
);

    localparam int unsigned     TW     = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]   T_LAST = TW'(CLKS_PER_BIT - 1);

    ser_state_e    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;
    logic          busy_n;
    logic          bit_end;

    assign bit_end = (timer == T_LAST);
    assign done_c  = (state == SER_STOP) && bit_end;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= SER_IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    // Next-state and next-output logic; tx_n is the line level for the coming cycle.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        tx_n      = tx;

        if (state != SER_IDLE) begin
            timer_n = bit_end ? '0 : TW'(timer + 1'b1);
        end

        case (state)
            SER_IDLE: begin
                if (start) begin
                    state_n = SER_START;
                    shift_n = data;
                    tx_n    = 1'b0;
                end
            end
            SER_START: begin
                if (bit_end) begin
                    state_n = SER_DATA;
                    tx_n    = shift[0];
                    shift_n = {1'b0, shift[7:1]};
                end
            end
            SER_DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_n   = SER_STOP;
                        bit_idx_n = '0;
                        tx_n      = 1'b1;
                    end else begin
                        bit_idx_n = 3'(bit_idx + 1'b1);
                        tx_n      = shift[0];
                        shift_n   = {1'b0, shift[7:1]};
                    end
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    if (start) begin
                        state_n = SER_START;
                        shift_n = data;
                        tx_n    = 1'b0;
                    end else begin
                        state_n = SER_IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = SER_IDLE;
                tx_n    = 1'b1;
            end
        endcase

        busy_n = (state_n != SER_IDLE);
    end

endmodule

// File: rtl/catcore_frame_tx.sv
// CatCore command-frame initiator: latches cmd/payload into a byte buffer and sends it 8N1
// with an idle-high gap after every byte. FRAME_BYTES may not exceed the 16-byte payload plus two cmds.
module catcore_frame_tx
    import catcore_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10752,
    parameter int unsigned FRAME_BYTES  = CATCORE_FRAME_BYTES,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 start,
    input  logic [7:0]           cmd,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [LEN_W-1:0]     frame_len,
    output logic                 busy,
    output logic                 done,
    output logic                 tx
);

    localparam int unsigned   IDXW     = $clog2(FRAME_BYTES);
    localparam int unsigned   GAP_CLKS = GAP_BITS * CLKS_PER_BIT;
    localparam int unsigned   GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GW-1:0] G_LAST   = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

    frm_state_e      state, state_n;
    logic [IDXW-1:0] byte_idx, byte_idx_n;
    logic [IDXW-1:0] last_idx;
    logic [IDXW-1:0] next_idx;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    logic            busy_n;
    logic            done_n;

    frame_req_t                       req_c;
    logic [LEN_W-1:0]                 len_c;
    logic [8*CATCORE_FRAME_BYTES-1:0] pay_ext;
    logic [7:0]                       load_buf  [FRAME_BYTES];
    logic [7:0]                       frame_buf [FRAME_BYTES];

    logic       accept_c;
    logic       last_byte_c;
    logic       ser_start_c;
    logic [7:0] ser_data_c;
    logic       ser_done_c;
    logic       ser_busy;

    assign req_c       = '{cmd: cmd, payload: payload, len: frame_len};
    assign len_c       = clamp_len(req_c.len, FRAME_BYTES);
    assign pay_ext     = {8'h00, req_c.payload, 8'h00};
    assign next_idx    = IDXW'(byte_idx + 1'b1);
    assign last_byte_c = (byte_idx == last_idx);
    assign accept_c    = start && ((state == FRM_IDLE) || (state == FRM_DONE)) && !ser_busy;

    // Byte k of the frame: cmd at both ends, payload byte k-1 in between.
    always_comb begin
        for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
            if ((k == 0) || (k == 32'(len_c) - 32'd1)) begin
                load_buf[k] = req_c.cmd;
            end else begin
                load_buf[k] = pay_ext[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
                frame_buf[k] <= '0;
            end
        end else if (accept_c) begin
            for (int unsigned k = 0; k < FRAME_BYTES; k++) begin
                frame_buf[k] <= load_buf[k];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= FRM_IDLE;
            byte_idx <= '0;
            last_idx <= '0;
            gap_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            gap_cnt  <= gap_cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            if (accept_c) begin
                last_idx <= IDXW'(len_c - LEN_W'(1));
            end
        end
    end

    // Byte sequencing; the serialiser is kicked in the same cycle the previous byte/gap ends.
    always_comb begin
        state_n     = state;
        byte_idx_n  = byte_idx;
        gap_cnt_n   = gap_cnt;
        ser_start_c = 1'b0;
        ser_data_c  = frame_buf[next_idx];

        case (state)
            FRM_IDLE, FRM_DONE: begin
                state_n = FRM_IDLE;
                if (accept_c) begin
                    state_n     = FRM_BYTE;
                    byte_idx_n  = '0;
                    ser_start_c = 1'b1;
                    ser_data_c  = req_c.cmd;
                end
            end
            FRM_BYTE: begin
                if (ser_done_c) begin
                    if (GAP_BITS != 0) begin
                        state_n   = FRM_GAP;
                        gap_cnt_n = '0;
                    end else if (last_byte_c) begin
                        state_n    = FRM_DONE;
                        byte_idx_n = '0;
                    end else begin
                        byte_idx_n  = next_idx;
                        ser_start_c = 1'b1;
                    end
                end
            end
            FRM_GAP: begin
                if (gap_cnt == G_LAST) begin
                    gap_cnt_n = '0;
                    if (last_byte_c) begin
                        state_n    = FRM_DONE;
                        byte_idx_n = '0;
                    end else begin
                        state_n     = FRM_BYTE;
                        byte_idx_n  = next_idx;
                        ser_start_c = 1'b1;
                    end
                end else begin
                    gap_cnt_n = GW'(gap_cnt + 1'b1);
                end
            end
            default: begin
                state_n = FRM_IDLE;
            end
        endcase

        busy_n = (state_n == FRM_BYTE) || (state_n == FRM_GAP);
        done_n = (state_n == FRM_DONE);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk    (clk),
        .nreset (nreset),
        .start  (ser_start_c),
        .data   (ser_data_c),
        .tx     (tx),
        .busy   (ser_busy),
        .done_c (ser_done_c)
    );

endmodule
